// File: rtl/slt_iter_unit.sv
// slt_iter_unit: multi-cycle chunked a-b compare producing SLT/SLTU/SEQ/SGE flags
// with valid/ready handshakes; CHUNK bits of the subtraction are resolved per cycle.
module slt_iter_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = $clog2(NCHUNK) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, nb_r;
    logic [1:0]       op_r;
    logic             carry, zero_acc;
    logic [CNT_W-1:0] cnt;
    logic [CHUNK:0]   sum;
    logic             accept, last, chunk_zero, cin_msb, ovf, lt_s, flag;

    assign accept     = in_valid && in_ready && !abort;
    assign last       = cnt == CNT_W'(NCHUNK - 1);
    assign sum        = {1'b0, a_r[cnt*CHUNK +: CHUNK]} + {1'b0, nb_r[cnt*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, carry};
    assign chunk_zero = sum[CHUNK-1:0] == '0;
    // Carry into the MSB column recovered from its sum bit; only meaningful on the last chunk.
    assign cin_msb    = sum[CHUNK-1] ^ a_r[WIDTH-1] ^ nb_r[WIDTH-1];
    assign ovf        = cin_msb ^ sum[CHUNK];
    assign lt_s       = sum[CHUNK-1] ^ ovf;
    assign flag       = op_r == 2'b00 ? lt_s :
                        op_r == 2'b01 ? ~sum[CHUNK] :
                        op_r == 2'b10 ? zero_acc && chunk_zero : ~lt_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? RUN : IDLE;
            RUN:     state_nx = abort ? IDLE : (last ? DONE : RUN);
            DONE:    state_nx = (abort || out_ready) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // Flags are registered at the final chunk edge so they are stable throughout DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            nb_r     <= '0;
            op_r     <= '0;
            carry    <= 1'b0;
            zero_acc <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_r      <= a;
            nb_r     <= ~b;
            op_r     <= op;
            carry    <= 1'b1;
            zero_acc <= 1'b1;
            cnt      <= '0;
        end else if (state == RUN && !abort) begin
            carry    <= sum[CHUNK];
            zero_acc <= zero_acc && chunk_zero;
            cnt      <= cnt + 1'b1;
            if (last) begin
                result   <= {{(WIDTH-1){1'b0}}, flag};
                overflow <= ovf;
                zero     <= zero_acc && chunk_zero;
            end
        end
    end
endmodule

// File: tb/tb_slt_iter_unit.sv
// tb_slt_iter_unit: checks a CHUNK=4 and a CHUNK=16 instance against a transaction-level
// compare model, with directed literal cases plus randomized handshake/abort traffic.
module tb_slt_iter_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rstn, iv, abt, ordy, ir, ovld, ovf, zr;
    logic [15:0] av[2], bv[2], res[2];
    logic [1:0]  opv[2];
    int checks = 0, failures = 0;

    task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %h want %h at %0t", nm, g, act, exp, $time);
        end
    endtask

    // Reference: {15'b0, flag, overflow, zero} straight from signed/unsigned arithmetic.
    function automatic logic [17:0] refv(logic [15:0] x, logic [15:0] y, logic [1:0] o);
        logic [15:0] d;
        logic v, lts, ltu, eq, f;
        d   = x - y;
        v   = (x[15] != y[15]) && (d[15] != x[15]);
        lts = $signed(x) < $signed(y);
        ltu = x < y;
        eq  = x == y;
        f   = o == 2'd0 ? lts : o == 2'd1 ? ltu : o == 2'd2 ? eq : !lts;
        return {15'b0, f, v, eq};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int N = g == 0 ? 4 : 1;
        slt_iter_unit #(.WIDTH(16), .CHUNK(g == 0 ? 4 : 16)) dut (
            .clk(clk), .rst_n(rstn[g]), .in_valid(iv[g]), .in_ready(ir[g]),
            .a(av[g]), .b(bv[g]), .op(opv[g]), .abort(abt[g]),
            .out_valid(ovld[g]), .out_ready(ordy[g]), .result(res[g]),
            .overflow(ovf[g]), .zero(zr[g])
        );
        bit          m_idle = 1'b1;
        int          m_left = 0;
        logic [17:0] pend = '0, m_out = '0;
        always @(posedge clk or negedge rstn[g]) begin
            if (!rstn[g]) begin
                m_idle <= 1'b1;
                m_left <= 0;
                m_out  <= '0;
            end else if (m_idle) begin
                if (iv[g] && !abt[g]) begin
                    pend   <= refv(av[g], bv[g], opv[g]);
                    m_left <= N;
                    m_idle <= 1'b0;
                end
            end else if (m_left > 0) begin
                if (abt[g]) m_idle <= 1'b1;
                else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_out <= pend;
                end
            end else if (abt[g] || ordy[g]) m_idle <= 1'b1;
        end
        always @(negedge clk) begin
            chk("in_ready", g, ir[g], m_idle);
            chk("out_valid", g, ovld[g], !m_idle && m_left == 0);
            chk("result", g, res[g], m_out[17:2]);
            chk("overflow", g, ovf[g], m_out[1]);
            chk("zero", g, zr[g], m_out[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int g, logic [15:0] x, logic [15:0] y, logic [1:0] o);
        iv[g] = 1'b1; av[g] = x; bv[g] = y; opv[g] = o;
        step();
        iv[g] = 1'b0; av[g] = 16'($urandom); bv[g] = 16'($urandom); opv[g] = 2'($urandom);
    endtask

    task automatic wait_valid(int g, output int n);
        n = 0;
        while (!ovld[g] && n < 40) begin
            step();
            n++;
        end
        chk("valid_timeout", g, n < 40, 1);
    endtask

    task automatic run_op(int g, logic [15:0] x, logic [15:0] y, logic [1:0] o,
                          logic [15:0] er, logic eo, logic ez);
        int n;
        issue(g, x, y, o);
        wait_valid(g, n);
        chk("lit_result", g, res[g], er);
        chk("lit_overflow", g, ovf[g], eo);
        chk("lit_zero", g, zr[g], ez);
        step();
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] sp[4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
        return $urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 3)] : 16'($urandom);
    endfunction

    task automatic rand_run(int g, int cycles);
        for (int i = 0; i < cycles; i++) begin
            iv[g]   = $urandom_range(0, 9) != 0;
            abt[g]  = $urandom_range(0, 49) == 0;
            ordy[g] = $urandom_range(0, 3) != 0;
            av[g]   = pick();
            bv[g]   = $urandom_range(0, 4) == 0 ? av[g] : pick();
            opv[g]  = 2'($urandom);
            step();
        end
        iv[g] = 1'b0; abt[g] = 1'b0; ordy[g] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        rstn = 2'b00; iv = '0; abt = '0; ordy = 2'b11;
        for (int g = 0; g < 2; g++) begin av[g] = '0; bv[g] = '0; opv[g] = '0; end
        repeat (2) step();
        for (int g = 0; g < 2; g++) begin
            chk("rst_valid", g, ovld[g], 0);
            chk("rst_result", g, res[g], 0);
        end
        rstn = 2'b11;
        step();
        chk("rst_ready", 0, ir[0], 1);
        run_op(0, 16'h7FFF, 16'h8000, 2'b00, 16'h0000, 1'b1, 1'b0);
        run_op(0, 16'h7FFF, 16'h8000, 2'b01, 16'h0001, 1'b1, 1'b0);
        run_op(0, 16'h8000, 16'h0001, 2'b00, 16'h0001, 1'b1, 1'b0);
        run_op(0, 16'h8000, 16'h0001, 2'b11, 16'h0000, 1'b1, 1'b0);
        run_op(0, 16'h1234, 16'h1234, 2'b10, 16'h0001, 1'b0, 1'b1);
        run_op(0, 16'h1234, 16'h1235, 2'b10, 16'h0000, 1'b0, 1'b0);
        run_op(1, 16'h7FFF, 16'h8000, 2'b01, 16'h0001, 1'b1, 1'b0);
        // Latency and back-pressure.
        ordy[0] = 1'b0;
        issue(0, 16'h0003, 16'h0005, 2'b00);
        wait_valid(0, n);
        chk("latency", 0, n, 4);
        repeat (5) begin
            chk("hold_valid", 0, ovld[0], 1);
            chk("hold_ready", 0, ir[0], 0);
            chk("hold_result", 0, res[0], 16'h0001);
            step();
        end
        ordy[0] = 1'b1;
        step();
        chk("drain_valid", 0, ovld[0], 0);
        chk("drain_ready", 0, ir[0], 1);
        issue(1, 16'h0005, 16'h0003, 2'b11);
        wait_valid(1, n);
        chk("latency", 1, n, 1);
        chk("lit_result", 1, res[1], 16'h0001);
        step();
        // Async reset mid-run clears the previous (nonzero) result immediately.
        issue(0, 16'h1111, 16'h2222, 2'b01);
        step();
        step();
        rstn[0] = 1'b0;
        #1;
        chk("async_valid", 0, ovld[0], 0);
        chk("async_result", 0, res[0], 16'h0000);
        step();
        rstn[0] = 1'b1;
        step();
        // Abort mid-run, then abort beating in_valid in IDLE.
        issue(0, 16'h1234, 16'h1234, 2'b10);
        step();
        abt[0] = 1'b1;
        step();
        abt[0] = 1'b0;
        chk("abort_ready", 0, ir[0], 1);
        repeat (6) begin
            chk("abort_novalid", 0, ovld[0], 0);
            step();
        end
        iv[0] = 1'b1; abt[0] = 1'b1;
        step();
        iv[0] = 1'b0; abt[0] = 1'b0;
        chk("abort_idle", 0, ir[0], 1);
        run_op(0, 16'h0003, 16'h0005, 2'b00, 16'h0001, 1'b0, 1'b0);
        fork
            rand_run(0, 8000);
            rand_run(1, 30000);
        join
        repeat (8) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
